// File: rtl/mul_pkg.sv
// mul_pkg: shared types and constants for the RV64 M-extension multiply pipe.
//   mul_op_e   - 3-bit multiply opcode as issued by the execute stage
//   mul_ctrl_t - per-stage control payload {op, neg}; the destination tag
//                rides beside it because its width is a parameter of the top
//   sext_word  - sign-extend bit 31 of a 64-bit value (word ops)
// Optional feature macro: MUL_WORD_OPS_EN (MULW support).
package mul_pkg;

    localparam int XLEN   = 64;
    localparam int PROD_W = 128;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_MULW   = 3'b100
    } mul_op_e;

    typedef struct packed {
        mul_op_e op;
        logic    neg;
    } mul_ctrl_t;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/dadda_multiplier.sv
// dadda_multiplier: unsigned 64x64 -> 128-bit combinational multiplier core.
//   a, b : unsigned 64-bit operands
//   p    : full 128-bit unsigned product
module dadda_multiplier (
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    output logic [127:0] p
);

    assign p = 128'(a) * 128'(b);

endmodule

// File: rtl/mul_operand_prep.sv
// mul_operand_prep: combinational S1 operand conditioning.
//   op_raw       : opcode from issue (undefined encodings fold to MUL)
//   rs1, rs2     : raw operands
//   op           : normalised opcode carried down the pipe
//   mag_a, mag_b : unsigned magnitudes fed to the multiplier
//   neg          : product must be negated in the fixup stage
// Optional feature macro: MUL_WORD_OPS_EN. When undefined, opcode 100 is
// folded to MUL and no word sign-extension logic exists.
module mul_operand_prep
    import mul_pkg::*;
(
    input  logic [2:0]      op_raw,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output mul_op_e         op,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg
);

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_val;
    logic [XLEN-1:0] b_val;

    always_comb begin
        op       = OP_MUL;
        a_signed = 1'b0;
        b_signed = 1'b0;
        a_val    = rs1;
        b_val    = rs2;
        case (op_raw)
            OP_MULH: begin
                op       = OP_MULH;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: begin
                op       = OP_MULHSU;
                a_signed = 1'b1;
            end
            OP_MULHU: op = OP_MULHU;
`ifdef MUL_WORD_OPS_EN
            // Word operands are sign-extended and then multiplied as
            // unsigned; only the low 32 product bits are kept, so no
            // sign correction is needed.
            OP_MULW: begin
                op    = OP_MULW;
                a_val = sext_word(rs1);
                b_val = sext_word(rs2);
            end
`endif
            default: op = OP_MUL;
        endcase

        a_neg = a_signed & a_val[XLEN-1];
        b_neg = b_signed & b_val[XLEN-1];
        // -2^63 negates to 0x8000_0000_0000_0000, which is its correct
        // unsigned magnitude.
        mag_a = a_neg ? -a_val : a_val;
        mag_b = b_neg ? -b_val : b_val;
        neg   = a_neg ^ b_neg;
    end

endmodule

// File: rtl/mul_unit_pipe.sv
// mul_unit_pipe: three-stage elastic RV64 M-extension multiply pipeline.
//   S1 prep     : latch op/tag, sign flag and operand magnitudes
//   S2 multiply : register the 128-bit product of the S1 magnitudes
//   S3 fixup    : sign-correct, select half/word, register the result
// Ports:
//   clk, rst_n (async active-low), flush (sync kill of all in-flight ops)
//   in_valid/in_ready, in_op, in_rs1, in_rs2, in_tag  : issue side
//   out_valid/out_ready, out_result, out_tag          : writeback side
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends combinationally on out_ready through the stage enables.
// Optional feature macro: MUL_WORD_OPS_EN (MULW support).
module mul_unit_pipe
    import mul_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam mul_ctrl_t CTRL_RST = '{op: OP_MUL, neg: 1'b0};

    // Prep outputs
    mul_op_e           prep_op;
    logic [XLEN-1:0]   prep_mag_a;
    logic [XLEN-1:0]   prep_mag_b;
    logic              prep_neg;
    logic [PROD_W-1:0] mult_prod;

    // S1
    logic              s1_valid_q, s1_valid_d;
    mul_ctrl_t         s1_ctrl_q, s1_ctrl_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic [XLEN-1:0]   s1_mag_a_q, s1_mag_a_d;
    logic [XLEN-1:0]   s1_mag_b_q, s1_mag_b_d;

    // S2
    logic              s2_valid_q, s2_valid_d;
    mul_ctrl_t         s2_ctrl_q, s2_ctrl_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d;

    // S3 (output register)
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;

    // Stage enables: a stage may load when it is empty or its contents
    // are leaving on the same edge.
    logic s3_free;
    logic s2_free;
    logic s1_free;

    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]   fix_result;

    mul_operand_prep u_prep (
        .op_raw (in_op),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .op     (prep_op),
        .mag_a  (prep_mag_a),
        .mag_b  (prep_mag_b),
        .neg    (prep_neg)
    );

    // Only register-to-register path through the multiplier: S1 -> S2.
    dadda_multiplier u_mult (
        .a (s1_mag_a_q),
        .b (s1_mag_b_q),
        .p (mult_prod)
    );

    assign s3_free  = !out_valid_q | out_ready;
    assign s2_free  = !s2_valid_q | s3_free;
    assign s1_free  = !s1_valid_q | s2_free;
    assign in_ready = s1_free;

    // S3 fixup: negating zero yields zero, so no special case.
    always_comb begin
        prod_fix = s2_ctrl_q.neg ? -s2_prod_q : s2_prod_q;
        case (s2_ctrl_q.op)
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[PROD_W-1:XLEN];
`ifdef MUL_WORD_OPS_EN
            OP_MULW:                      fix_result = sext_word(prod_fix[XLEN-1:0]);
`endif
            default:                      fix_result = prod_fix[XLEN-1:0];
        endcase
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_ctrl_d    = s1_ctrl_q;
        s1_tag_d     = s1_tag_q;
        s1_mag_a_d   = s1_mag_a_q;
        s1_mag_b_d   = s1_mag_b_q;
        s2_valid_d   = s2_valid_q;
        s2_ctrl_d    = s2_ctrl_q;
        s2_tag_d     = s2_tag_q;
        s2_prod_d    = s2_prod_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (s1_free) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ctrl_d  = '{op: prep_op, neg: prep_neg};
                s1_tag_d   = in_tag;
                s1_mag_a_d = prep_mag_a;
                s1_mag_b_d = prep_mag_b;
            end
        end

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_ctrl_d = s1_ctrl_q;
                s2_tag_d  = s1_tag_q;
                s2_prod_d = mult_prod;
            end
        end

        // Output data only changes when a real op lands, so it holds
        // steady while stalled and through bubbles.
        if (s3_free) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_result_d = fix_result;
                out_tag_d    = s2_tag_q;
            end
        end

        // Flush kills every valid bit, including an op handshaking this
        // cycle; data registers are left as they are.
        if (flush) begin
            s1_valid_d  = 1'b0;
            s2_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_ctrl_q    <= CTRL_RST;
            s1_tag_q     <= '0;
            s1_mag_a_q   <= '0;
            s1_mag_b_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_ctrl_q    <= CTRL_RST;
            s2_tag_q     <= '0;
            s2_prod_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_tag_q     <= s1_tag_d;
            s1_mag_a_q   <= s1_mag_a_d;
            s1_mag_b_q   <= s1_mag_b_d;
            s2_valid_q   <= s2_valid_d;
            s2_ctrl_q    <= s2_ctrl_d;
            s2_tag_q     <= s2_tag_d;
            s2_prod_q    <= s2_prod_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule
